// File: rtl/thread_scheduler_wrr_pkg.sv
// Shared definitions for the weighted round-robin thread scheduler.
//   n_threads  : default number of hardware threads
//   tid_width  : width of a thread identifier for n_threads threads
//   w_w        : default width of one per-thread weight field
//   weight_t   : one weight field
//   threadid_t : thread identifier
package thread_scheduler_wrr_pkg;

  localparam int n_threads = 8;
  localparam int tid_width = $clog2(n_threads);
  localparam int w_w       = 4;

  typedef logic [w_w-1:0]       weight_t;
  typedef logic [tid_width-1:0] threadid_t;

endpackage

// File: rtl/thread_scheduler_wrr_find_first.sv
// rr_find_first: combinational rotating priority encoder.
// Scans the eligible mask starting at 'start' and wrapping modulo N.
//   eligible      in  N      bit i = 1 means entry i may be picked
//   start         in  IDX_W  rotation origin
//   include_start in  1      1: scan start, start+1, ...; 0: scan start+1, ..., start
//   found         out 1      some eligible entry exists
//   index         out IDX_W  first eligible entry in scan order (start when none)
// N must be a power of two so that wrap-around is plain truncation.
module rr_find_first
  import thread_scheduler_wrr_pkg::*;
#(
  parameter int N     = n_threads,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     eligible,
  input  logic [IDX_W-1:0] start,
  input  logic             include_start,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  logic [IDX_W-1:0] first_off;

  // Excluding the origin shifts the window by one, which moves the origin
  // itself to the last scan slot.
  assign first_off = include_start ? IDX_W'(0) : IDX_W'(1);

  always_comb begin
    logic [IDX_W-1:0] cand;
    found = 1'b0;
    index = start;
    cand  = start;
    for (int k = 0; k < N; k++) begin
      cand = start + first_off + IDX_W'(k);
      if (!found && eligible[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler_wrr.sv
// thread_scheduler_wrr: weighted round-robin hardware thread selector for
// the fetch stage. One thread is chosen per cycle; a chosen thread keeps
// issuing for its weight in cycles unless it stalls, after which selection
// rotates to the next unstalled thread. An exception redirect overrides
// everything except reset.
//   clk        in  1              clock
//   rst        in  1              synchronous reset, active-high
//   stalled    in  N_THREADS      bit i = 1: thread i cannot issue
//   weights    in  N_THREADS*W_W  burst length of thread i at [i*W_W +: W_W] (0 means 1)
//   exc_en     in  1              exception redirect request
//   exc_thread in  TID_W          redirect target
//   thread     out TID_W          selected thread (registered)
//   valid      out 1              thread is meaningful
//   switched   out 1              pulse: thread changed, or valid rose
//
// Output protocol: there is no ready; the consumer must take 'thread'
// every cycle in which 'valid' is 1. When 'valid' is 0 no thread could
// issue and 'thread' still holds the last selection.
module thread_scheduler_wrr
  import thread_scheduler_wrr_pkg::*;
#(
  parameter int N_THREADS = n_threads,
  parameter int W_W       = w_w,
  parameter int WEIGHTED  = 1,
  parameter int TID_W     = $clog2(N_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_THREADS-1:0]     stalled,
  input  logic [N_THREADS*W_W-1:0] weights,
  input  logic                     exc_en,
  input  logic [TID_W-1:0]         exc_thread,
  output logic [TID_W-1:0]         thread,
  output logic                     valid,
  output logic                     switched
);

  // Remaining extra cycles of the current burst; 0 means rotate next edge.
  logic [W_W-1:0] burst_cnt;

  // Effective weights: zero weight, or the unweighted build, means one cycle.
  logic [W_W-1:0] eff_w [N_THREADS];

  for (genvar gi = 0; gi < N_THREADS; gi++) begin : g_eff_w
    assign eff_w[gi] = ((WEIGHTED == 0) || (weights[gi*W_W +: W_W] == '0))
                       ? W_W'(1) : weights[gi*W_W +: W_W];
  end

  // Rotating search. While valid, the current thread is examined last so
  // that others get a turn; from idle the scan begins at the current thread.
  logic             srch_found;
  logic [TID_W-1:0] srch_idx;

  rr_find_first #(
    .N     (N_THREADS),
    .IDX_W (TID_W)
  ) u_find (
    .eligible      (~stalled),
    .start         (thread),
    .include_start (~valid),
    .found         (srch_found),
    .index         (srch_idx)
  );

  logic             hold;
  logic [TID_W-1:0] nxt_thread;
  logic             nxt_valid;
  logic [W_W-1:0]   nxt_cnt;
  logic             nxt_switched;

  // A stall on the current thread drops out of the hold and discards the
  // rest of the burst.
  assign hold = valid && !stalled[thread] && (burst_cnt != '0);

  always_comb begin
    nxt_thread = thread;
    nxt_valid  = valid;
    nxt_cnt    = burst_cnt;
    if (exc_en) begin
      // The redirect target is taken even when it is stalled.
      nxt_thread = exc_thread;
      nxt_valid  = 1'b1;
      nxt_cnt    = eff_w[exc_thread] - W_W'(1);
    end else if (hold) begin
      nxt_cnt    = burst_cnt - W_W'(1);
    end else if (srch_found) begin
      nxt_thread = srch_idx;
      nxt_valid  = 1'b1;
      nxt_cnt    = eff_w[srch_idx] - W_W'(1);
    end else begin
      nxt_valid  = 1'b0;
    end
    nxt_switched = (nxt_thread != thread) || (nxt_valid && !valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      thread    <= '0;
      valid     <= 1'b0;
      switched  <= 1'b0;
      burst_cnt <= '0;
    end else begin
      thread    <= nxt_thread;
      valid     <= nxt_valid;
      switched  <= nxt_switched;
      burst_cnt <= nxt_cnt;
    end
  end

endmodule

// File: doc/thread_scheduler_wrr.md
Name: thread_scheduler_wrr

Overview:
- Parametrised weighted round-robin thread scheduler for the fetch stage of the multithreaded core.
- Picks one hardware thread per cycle.
- Each selected thread may keep issuing for a programmable burst (weight) before the scheduler rotates.
- Stalled threads are skipped; exceptions force an immediate redirect.
- Reports an idle cycle when every thread is stalled.

Parameters:
- N_THREADS, 8, number of hardware threads; must be ≥2 and a power of two.
- W_W, 4, width of each per-thread weight field.
- WEIGHTED, 1, 1 = weighted bursts enabled; 0 = every weight is forced to 1 (plain stall-aware round robin).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- stalled  in  N_THREADS  bit i = 1 means thread i cannot issue this cycle.
- weights  in  N_THREADS*W_W  burst length of thread i in bits [i*W_W +: W_W]; a value of 0 is treated as 1.
- exc_en  in  1  exception redirect request.
- exc_thread  in  TID_W  thread to redirect to.
- thread  out  TID_W  selected thread, registered.
- valid  out  1  thread output is meaningful (at least one thread was eligible).
- switched  out  1  one-cycle pulse: thread changed value, or valid rose, on this edge.

Behaviour:
- TID_W = $clog2(N_THREADS). All outputs are registered and update on posedge clk. Selection latency is 1 cycle from the stalled/exc inputs.
- Internal state: burst counter burst_cnt, W_W bits.
- Reset (rst = 1 at an edge, including mid-burst): thread = 0, valid = 0, switched = 0, burst_cnt = 0. Reset overrides exc_en.
- Effective weight: eff_w(i) = 1 if WEIGHTED = 0 or weights[i] = 0; otherwise weights[i].
- Priority per edge, highest first:
  1. exc_en = 1:
     - thread <= exc_thread, valid <= 1, burst_cnt <= eff_w(exc_thread) - 1.
     - Applies even if exc_thread is stalled; the exception overrides the stall.
  2. Hold: valid = 1, stalled[thread] = 0 and burst_cnt ≠ 0:
     - thread unchanged, burst_cnt <= burst_cnt - 1.
  3. Search:
     - Candidate order is (thread + k) mod N_THREADS.
     - If valid = 1, k = 1..N_THREADS, so the current thread is checked last.
     - If valid = 0, k = 0..N_THREADS-1, so the search starts at the current thread.
     - First candidate with stalled = 0 wins: thread <= it, valid <= 1, burst_cnt <= eff_w(winner) - 1.
     - No candidate found: valid <= 0, thread and burst_cnt hold.
- A stall on the current thread mid-burst aborts the burst immediately. The search picks the next eligible thread, and the remaining count is discarded.
- Wrap-around: index arithmetic is modulo N_THREADS, done by truncation to TID_W bits.
- Weights are sampled only when a thread is selected. Changing weights mid-burst has no effect until the next selection.
- switched <= 1 when the new thread differs from the old one, or when valid goes 0→1. Otherwise switched <= 0. An exception to the already-current thread gives switched = 0.
- Single eligible thread: it is reselected every cycle; switched = 0 after the first selection.

Decomposition:
- Shared package common gains:
  - n_threads (default for N_THREADS).
  - tid_width = $clog2(n_threads).
  - weight_t (logic [W_W-1:0]).
- threadid_t remains the TID_W-bit thread type.
- Sub-module rr_find_first:
  - Combinational rotate-priority-encode.
  - Inputs: eligible mask, start index, include_start flag.
  - Outputs: found, index.
  - Reusable by the LSU arbiter.

Test Plan (N_THREADS = 8, W_W = 4, WEIGHTED = 1 unless noted):
1. Reset, then rst = 0, stalled = 0, weights all 0 → valid = 1 and thread = 0 one cycle after release, then 1, 2, …, 7, 0; switched = 1 on every cycle.
2. weights[2] = 3, others 1, no stalls → sequence 0, 1, 2, 2, 2, 3, …; switched = 0 on the two repeat cycles.
3. stalled = 8'b1111_1110 held → thread stays 0, switched = 0. Then stalled = 8'hFF → valid = 0 and thread holds 0. Then stalled = 8'b1011_1111 → thread = 6, valid = 1, switched = 1.
4. Thread 5 mid-burst with weight 4 (burst_cnt = 2), stalled[5] rises → next cycle thread = 6. On wrap 7 → 0, thread 0 is chosen when it is not stalled.
5. exc_en = 1, exc_thread = 3, stalled[3] = 1 during a burst on thread 1 → next cycle thread = 3, valid = 1. When exc_en and rst are both 1 → reset values.
6. WEIGHTED = 0 build with weights[2] = 5 → pure rotation 0..7, identical to scenario 1.
